// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS32 subset core with a unified memory port
// Ports: clk, reset (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in
//        (transfer completes when mem_req && mem_ready); halted (syscall), fault (misalign/undefined/watchdog);
//        dbg_pc mirrors the PC register.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           dbg_pc
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0C, FN_ADD = 6'h20, FN_ADDU = 6'h21,
                           FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                           FN_SLT = 6'h2A;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, ir, a, b, alu_out, alu_n, mdr, target, alu_res;
    logic [31:0] regs [0:31];
    logic [31:0] wait_cnt;
    logic        set_fault, set_halt;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wb_dst;
    logic [31:0] simm, wb_data, addr_next;
    logic        xfer, wd_trip, is_sw;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign simm    = {{16{ir[15]}}, ir[15:0]};
    assign is_sw   = (op == OP_SW);
    assign xfer    = mem_req && mem_ready;
    // Trips on the wait cycle that brings the counter to MAX_WAIT, so mem_req drops on the following cycle.
    assign wd_trip = (MAX_WAIT != 0) && mem_req && !mem_ready && (wait_cnt == MAX_WAIT - 1);
    assign wb_dst  = (op == OP_RTYPE) ? rd : rt;
    assign wb_data = (op == OP_LW) ? mdr : alu_out;
    assign dbg_pc  = pc;

    always_comb begin
        alu_res = a + simm;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_ADDU: alu_res = a + b;
                FN_SUB, FN_SUBU: alu_res = a - b;
                FN_AND:          alu_res = a & b;
                FN_OR:           alu_res = a | b;
                FN_SLT:          alu_res = {31'd0, $signed(a) < $signed(b)};
                default:         alu_res = a + b;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        alu_n     = alu_out;
        set_fault = 1'b0;
        set_halt  = 1'b0;
        case (state)
            S_FETCH: begin
                if (xfer) begin
                    state_n = S_DECODE;
                    pc_n    = pc + 32'd4;
                end else if (wd_trip) begin
                    state_n   = S_HALT;
                    set_fault = 1'b1;
                end
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                alu_n = alu_res;
                case (op)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT: state_n = S_WB;
                            FN_JR: begin
                                state_n = S_FETCH;
                                pc_n    = a;
                            end
                            FN_SYSCALL: begin
                                state_n  = S_HALT;
                                set_halt = 1'b1;
                            end
                            default: begin
                                state_n   = S_HALT;
                                set_fault = 1'b1;
                            end
                        endcase
                    end
                    OP_ADDI, OP_ADDIU: state_n = S_WB;
                    OP_LW, OP_SW: begin
                        if (alu_res[1:0] != 2'b00) begin
                            state_n   = S_HALT;
                            set_fault = 1'b1;
                        end else begin
                            state_n = S_MEM;
                        end
                    end
                    OP_BEQ: begin
                        state_n = S_FETCH;
                        if (a == b) pc_n = target;
                    end
                    OP_BNE: begin
                        state_n = S_FETCH;
                        if (a != b) pc_n = target;
                    end
                    OP_J, OP_JAL: begin
                        state_n = S_FETCH;
                        pc_n    = {pc[31:28], ir[25:0], 2'b00};
                    end
                    default: begin
                        state_n   = S_HALT;
                        set_fault = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (xfer) begin
                    state_n = is_sw ? S_FETCH : S_WB;
                end else if (wd_trip) begin
                    state_n   = S_HALT;
                    set_fault = 1'b1;
                end
            end
            S_WB:    state_n = S_FETCH;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_HALT;
        endcase
    end

    // Port outputs are registered from the next state so a request is already on the bus
    // in the first cycle of FETCH/MEM, which is what makes zero-wait transfers single-cycle.
    assign addr_next = (state_n == S_MEM) ? alu_n : pc_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            target    <= '0;
            wait_cnt  <= '0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc      <= pc_n;
            alu_out <= alu_n;
            if (state == S_FETCH && xfer) ir <= mem_rdata;
            if (state == S_DECODE) begin
                a      <= regs[rs];
                b      <= regs[rt];
                target <= pc + (simm << 2);
            end
            if (state == S_MEM && xfer && !is_sw) mdr <= mem_rdata;
            if (state == S_EXEC && op == OP_JAL) regs[31] <= pc;
            if (state == S_WB && wb_dst != 5'd0) regs[wb_dst] <= wb_data;

            if (xfer)         wait_cnt <= '0;
            else if (mem_req) wait_cnt <= wait_cnt + 32'd1;

            halted    <= halted | set_halt;
            fault     <= fault | set_fault;
            mem_req   <= (state_n == S_FETCH) || (state_n == S_MEM);
            mem_we    <= (state_n == S_MEM) && is_sw;
            mem_addr  <= addr_next[ADDR_WIDTH-1:0];
            mem_wdata <= b;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - directed self-checking bench for mips_multicycle_core
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, halted, fault;
    logic [31:0] mem_addr, mem_wdata, dbg_pc;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    mips_multicycle_core #(.RESET_PC(32'h0000_0100), .ADDR_WIDTH(32), .MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .fault(fault), .dbg_pc(dbg_pc)
    );

    int checks = 0;
    int failures = 0;

    // imem is owned by the tests; stores land in dmem, tagged with the current program generation.
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    int          dgen [0:255];
    int          gen = 1;
    int          wait_n = 0;
    bit          hold_ready = 1'b0;

    int          cyc = 0, wcnt = 0, stab_err = 0, xfers = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;
    logic [7:0]  widx;
    logic [31:0] flog_addr [$];
    int          flog_cyc [$];

    function automatic logic [31:0] rd_word(input logic [31:0] addr);
        logic [7:0] i;
        i = addr[9:2];
        return (dgen[i] == gen) ? dmem[i] : imem[i];
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int tgt);
        return {op[5:0], tgt[27:2]};
    endfunction

    localparam logic [31:0] SYSCALL = 32'h0000_000C;

    always @(posedge clk) begin
        cyc++;
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                widx = mem_addr[9:2];
                dmem[widx] = mem_wdata;
                dgen[widx] = gen;
            end else begin
                flog_addr.push_back(mem_addr);
                flog_cyc.push_back(cyc);
            end
            xfers++;
            wcnt = 0;
            prev_wait = 1'b0;
        end else if (mem_req) begin
            if (prev_wait && (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata)) stab_err++;
            s_addr = mem_addr;
            s_we = mem_we;
            s_wdata = mem_wdata;
            prev_wait = 1'b1;
            wcnt++;
        end else begin
            wcnt = 0;
            prev_wait = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mem_req && !hold_ready && wcnt >= wait_n) begin
            mem_ready = 1'b1;
            mem_rdata = rd_word(mem_addr);
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
        gen++;
    endtask

    task automatic put(input int k, input logic [31:0] w);
        imem[64 + k] = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_stop(input int max, output int cycles, output bit ok);
        int c0;
        int n;
        ok = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        c0 = cyc;
        for (int i = 0; i < max; i++) begin
            if (halted || fault) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cycles = cyc - c0;
    endtask

    task automatic load_basic();
        clear_mem();
        put(0, enc_i(8, 0, 1, 5));
        put(1, enc_i(8, 0, 2, 7));
        put(2, enc_r(1, 2, 3, 'h20));
        put(3, enc_i('h2B, 0, 3, 'h10));
        put(4, enc_i('h23, 0, 4, 'h10));
        put(5, SYSCALL);
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
        checks++; if (dbg_pc !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=00000100", dbg_pc); end
    endtask

    task automatic test_zero_wait();
        int cycles;
        bit ok;
        wait_n = 0;
        load_basic();
        do_reset();
        run_until_stop(200, cycles, ok);
        checks++; if (!ok) begin failures++; $display("FAIL zw_timeout got=running exp=stopped"); end
        checks++; if (cycles != 24) begin failures++; $display("FAIL zw_cycles got=%0d exp=24", cycles); end
        checks++; if (halted !== 1'b1 || fault !== 1'b0) begin failures++; $display("FAIL zw_status got=h%b f%b exp=h1 f0", halted, fault); end
        checks++; if (rd_word(32'h10) !== 32'd12) begin failures++; $display("FAIL zw_mem got=%0d exp=12", rd_word(32'h10)); end
        checks++; if (dut.regs[4] !== 32'd12) begin failures++; $display("FAIL zw_r4 got=%0d exp=12", dut.regs[4]); end
    endtask

    task automatic test_branch_jump();
        int base;
        int n;
        logic [31:0] exp_a [7] = '{32'h100, 32'h104, 32'h40, 32'h44, 32'h108, 32'h108, 32'h108};
        int          exp_c [7] = '{0, 3, 6, 10, 13, 16, 19};
        wait_n = 0;
        clear_mem();
        put(0, enc_i(5, 0, 0, 5));
        put(1, enc_j(3, 'h40));
        put(2, enc_i(4, 0, 0, -1));
        imem[16] = enc_i(8, 0, 5, 3);
        imem[17] = enc_r(31, 0, 0, 'h08);
        do_reset();
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        base = flog_addr.size();
        repeat (22) @(negedge clk);
        checks++;
        if (flog_addr.size() - base < 7) begin
            failures++;
            $display("FAIL br_fetch_count got=%0d exp>=7", flog_addr.size() - base);
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (flog_addr[base + i] !== exp_a[i] || flog_cyc[base + i] - flog_cyc[base] != exp_c[i]) begin
                    failures++;
                    $display("FAIL br_fetch%0d got=%h@%0d exp=%h@%0d", i, flog_addr[base + i],
                             flog_cyc[base + i] - flog_cyc[base], exp_a[i], exp_c[i]);
                end
            end
        end
        checks++; if (dut.regs[31] !== 32'h108) begin failures++; $display("FAIL br_r31 got=%h exp=00000108", dut.regs[31]); end
        checks++; if (dut.regs[5] !== 32'd3) begin failures++; $display("FAIL br_r5 got=%0d exp=3", dut.regs[5]); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL br_status got=h%b f%b exp=h0 f0", halted, fault); end
    endtask

    task automatic test_wait_states();
        int cycles;
        int s0;
        bit ok;
        wait_n = 3;
        load_basic();
        do_reset();
        s0 = stab_err;
        run_until_stop(400, cycles, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ws_timeout got=running exp=stopped"); end
        checks++; if (cycles != 48) begin failures++; $display("FAIL ws_cycles got=%0d exp=48", cycles); end
        checks++; if (stab_err != s0) begin failures++; $display("FAIL ws_stable got=%0d exp=0 changes", stab_err - s0); end
        checks++; if (dut.regs[4] !== 32'd12 || rd_word(32'h10) !== 32'd12) begin failures++; $display("FAIL ws_result got=r4 %0d mem %0d exp=12", dut.regs[4], rd_word(32'h10)); end
        checks++; if (halted !== 1'b1 || fault !== 1'b0) begin failures++; $display("FAIL ws_status got=h%b f%b exp=h1 f0", halted, fault); end
        wait_n = 0;
    endtask

    task automatic test_watchdog();
        int n;
        load_basic();
        hold_ready = 1'b1;
        do_reset();
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (15) @(negedge clk);
        checks++; if (mem_req !== 1'b1 || fault !== 1'b0) begin failures++; $display("FAIL wd_early got=req%b f%b exp=req1 f0", mem_req, fault); end
        @(negedge clk);
        checks++; if (fault !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL wd_trip got=f%b req%b exp=f1 req0", fault, mem_req); end
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b0 || halted !== 1'b0 || dbg_pc !== 32'h100) begin failures++; $display("FAIL wd_after got=req%b h%b pc%h exp=req0 h0 pc00000100", mem_req, halted, dbg_pc); end
        hold_ready = 1'b0;
    endtask

    task automatic test_faults();
        int cycles;
        int x0;
        bit ok;
        clear_mem();
        put(0, enc_i('h23, 0, 1, 2));
        do_reset();
        x0 = xfers;
        run_until_stop(50, cycles, ok);
        checks++; if (fault !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL mis_status got=f%b h%b exp=f1 h0", fault, halted); end
        checks++; if (xfers - x0 != 1 || cycles != 3) begin failures++; $display("FAIL mis_noreq got=xfers %0d cyc %0d exp=1 3", xfers - x0, cycles); end

        clear_mem();
        put(0, 32'hFC00_0000);
        do_reset();
        run_until_stop(50, cycles, ok);
        checks++; if (fault !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL undef_status got=f%b h%b exp=f1 h0", fault, halted); end

        clear_mem();
        put(0, enc_i(8, 0, 1, 7));
        put(1, enc_i(8, 0, 0, 9));
        put(2, enc_r(0, 0, 1, 'h20));
        put(3, SYSCALL);
        do_reset();
        run_until_stop(100, cycles, ok);
        checks++; if (dut.regs[1] !== 32'd0 || dut.regs[0] !== 32'd0) begin failures++; $display("FAIL r0_write got=r1 %0d r0 %0d exp=0 0", dut.regs[1], dut.regs[0]); end
        checks++; if (halted !== 1'b1 || fault !== 1'b0) begin failures++; $display("FAIL r0_status got=h%b f%b exp=h1 f0", halted, fault); end
    endtask

    task automatic test_reset_mid_store();
        int cycles;
        int n;
        int nz;
        bit ok;
        clear_mem();
        put(0, enc_i(8, 0, 1, 'h55));
        put(1, enc_i('h2B, 0, 1, 'h20));
        put(2, SYSCALL);
        wait_n = 5;
        do_reset();
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(mem_req && mem_we) && n < 100);
        checks++; if (!(mem_req && mem_we)) begin failures++; $display("FAIL rm_store_seen got=req%b we%b exp=req1 we1", mem_req, mem_we); end
        reset = 1'b1;
        @(negedge clk);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'd0) nz++;
        checks++; if (mem_req !== 1'b0 || dbg_pc !== 32'h100) begin failures++; $display("FAIL rm_drop got=req%b pc%h exp=req0 pc00000100", mem_req, dbg_pc); end
        checks++; if (rd_word(32'h20) !== 32'd0 || nz != 0) begin failures++; $display("FAIL rm_nowrite got=mem %h nzregs %0d exp=0 0", rd_word(32'h20), nz); end
        reset = 1'b0;
        wait_n = 0;
        run_until_stop(100, cycles, ok);
        checks++; if (halted !== 1'b1 || rd_word(32'h20) !== 32'h55) begin failures++; $display("FAIL rm_resume got=h%b mem %h exp=h1 00000055", halted, rd_word(32'h20)); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_branch_jump();
        test_wait_states();
        test_watchdog();
        test_faults();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Multi-cycle MIPS32 subset core: the parametrised successor to the single-cycle CPU top level. It shares one ALU and adder across cycles, and a single unified instruction/data memory port with a req/ready handshake. This lets it run against wait-stated memory. Adds a bus watchdog, a halt instruction and misalignment fault detection, none of which the single-cycle CPU has.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_WIDTH, 32, width of mem_addr; upper PC bits above ADDR_WIDTH dropped on the port only
MAX_WAIT, 16, cycles a request may wait for mem_ready before fault; 0 disables watchdog

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous active-high reset
mem_req  output  1  memory request valid
mem_we  output  1  1 = store, 0 = load/fetch; qualified by mem_req
mem_addr  output  ADDR_WIDTH  byte address, word aligned
mem_wdata  output  32  store data
mem_rdata  input  32  load/fetch data, valid when mem_ready
mem_ready  input  1  transfer completes in any cycle where mem_req && mem_ready
halted  output  1  core stopped by syscall
fault  output  1  core stopped by misalignment or watchdog timeout
dbg_pc  output  32  current PC

Behaviour:
- Clock is clk; reset is synchronous, active-high, and fixed as such.
- Reset: pc=RESET_PC, state=FETCH, regs r0..r31=0, IR/A/B/ALUOut/MDR=0, mem_req=0, mem_we=0, halted=0, fault=0, wait counter=0. Reset asserted mid-transaction drops mem_req on the next edge; no write is issued after reset is sampled.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are registered.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
- DECODE: A<=R[rs], B<=R[rt], target<=pc+(sext(imm16)<<2). Go to EXEC.
- EXEC, by opcode/funct:
  - R-type add/addu, sub/subu, and, or, slt: ALUOut<=A op B, go to WB.
  - addi/addiu: A+sext(imm), go to WB.
  - lw/sw: ALUOut<=A+sext(imm). If bits [1:0]!=0, go to HALT with fault=1; otherwise go to MEM.
  - beq/bne: if condition holds, pc<=target. Go to FETCH.
  - j: pc<={pc[31:28],addr26,2'b00}. Go to FETCH.
  - jal: as j, plus r31<=pc (already +4).
  - jr: pc<=A. Go to FETCH.
  - syscall (op 0, funct 0x0C): go to HALT with halted=1.
  - Any other encoding: go to HALT with fault=1.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B. On ready: lw sets MDR<=mem_rdata and goes to WB; sw goes to FETCH.
- WB: R-type writes R[rd]<=ALUOut; addi writes R[rt]<=ALUOut; lw writes R[rt]<=MDR. Writes to r0 are discarded, so r0 always reads 0.
- Arithmetic: 32-bit wraparound; overflow is ignored for add/sub/addi. slt is a signed compare.
- Handshake:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until ready.
  - Zero-wait is allowed: mem_ready in the first req cycle completes the transfer.
  - mem_ready while mem_req=0 is ignored.
- Cycle counts at zero-wait: R-type/addi 4, lw 5, sw 4, beq/bne/j/jal/jr 3. Each wait cycle adds 1.
- Watchdog: the counter increments on each mem_req && !mem_ready cycle and clears on completion. When it reaches MAX_WAIT (MAX_WAIT>0), the core deasserts mem_req next cycle and goes to HALT with fault=1.
- HALT: mem_req=0. halted/fault stay sticky until reset; pc and regs are frozen. halted and fault are never both 1.
- dbg_pc = pc register.

Test Plan:
- Zero-wait program: addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0x10(r0); lw r4,0x10(r0); syscall -> mem[0x10]=12, r4=12, halted=1 at cycle 4+4+4+4+5+3=24, fault=0.
- Branch/jump: beq taken with offset -1 loops; bne falls through; jal 0x40 -> r31=pc_of_jal+4, pc=0x40; jr r31 returns. Each control transfer takes exactly 3 cycles.
- Wait states: mem_ready delayed 3 cycles per access -> identical architectural results to the zero-wait run. Outputs are stable during waits and the cycle count grows by 3 per access.
- Watchdog: MAX_WAIT=16 with mem_ready held 0 -> fault=1 after 16 wait cycles; mem_req=0 thereafter; halted=0.
- Faults: lw r1,2(r0) -> fault=1 with no memory request issued. Undefined opcode 6'h3F -> fault=1. addi r0,r0,9 followed by add r1,r0,r0 -> r1=0.
- Reset mid-sw-MEM (ready low): mem_req=0 next cycle, no write observed, pc=RESET_PC, all regs=0, FETCH resumes.
